// File: rtl/multi_alarm_clock_if.sv
// UART receive byte stream feeding the alarm clock command parser.
interface multi_alarm_clock_if;
  logic       bu_rx_data_rdy;
  logic [7:0] bu_rx_data;

  modport master (output bu_rx_data_rdy, output bu_rx_data);
  modport slave  (input  bu_rx_data_rdy, input  bu_rx_data);
endinterface

// File: rtl/multi_alarm_clock.sv
// MM:SS clock with NUM_ALARMS alarm channels, programmed by ASCII commands from a UART.
// Optional build macro TRIG_TIMEOUT_EN: a triggered alarm re-arms itself after 60 seconds.
module multi_alarm_clock #(
  parameter int NUM_ALARMS = 2,
  parameter int SEL_W      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  oneSecStrb,
  multi_alarm_clock_if.slave    rx,
  input  logic [SEL_W-1:0]      alarm_sel,
  output logic [15:0]           time_bcd,
  output logic [15:0]           alarm_bcd,
  output logic                  running,
  output logic [NUM_ALARMS-1:0] armed,
  output logic [NUM_ALARMS-1:0] trig,
  output logic                  cmd_err
);

  typedef enum logic [2:0] {P_IDLE, P_SEL, P_D0, P_D1, P_D2, P_D3, P_CR} pstate_e;
  typedef enum logic [1:0] {CMD_TIME, CMD_ALARM, CMD_TOGGLE} cmd_e;
  typedef enum logic [1:0] {A_IDLE, A_ARMED, A_TRIG} astate_e;

  localparam logic [7:0] CH_L  = 8'h6C;
  localparam logic [7:0] CH_A  = 8'h61;
  localparam logic [7:0] CH_AT = 8'h40;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_0  = 8'h30;

  pstate_e     pstate_q, pstate_d;
  cmd_e        cmd_q, cmd_d;
  logic [3:0]  sel_q, sel_d;
  logic [15:0] shadow_q, shadow_d;
  logic        err_q, err_d;
  logic [15:0] time_q, time_d;
  logic [15:0] alarm_q [NUM_ALARMS];
  logic [15:0] alarm_d [NUM_ALARMS];
  astate_e     astate_q [NUM_ALARMS];
  astate_e     astate_d [NUM_ALARMS];

  logic [7:0]  rx_byte;
  logic        sel_ok;
  logic        tick;
  logic        commit_time;
  logic        commit_alarm;
  logic        toggle_hit;
  logic [3:0]  toggle_idx;

  function automatic logic digit_ok(input logic [7:0] c, input logic [3:0] max_d);
    return (c >= CH_0) && (c <= CH_0 + {4'd0, max_d});
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd9) begin
      r[3:0] = t[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (t[7:4] != 4'd5) begin
        r[7:4] = t[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (t[11:8] != 4'd9) begin
          r[11:8] = t[11:8] + 4'd1;
        end else begin
          r[11:8]  = 4'd0;
          r[15:12] = (t[15:12] == 4'd5) ? 4'd0 : t[15:12] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign rx_byte = rx.bu_rx_data;
  assign sel_ok  = (rx_byte >= CH_0) && (rx_byte < CH_0 + 8'(NUM_ALARMS));
  assign running = (pstate_q == P_IDLE);
  assign tick    = oneSecStrb && running;

  // Command parser: digits collect in the shadow and only reach live registers on CR.
  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    logic abort;
    pstate_d     = pstate_q;
    cmd_d        = cmd_q;
    sel_d        = sel_q;
    shadow_d     = shadow_q;
    err_d        = 1'b0;
    commit_time  = 1'b0;
    commit_alarm = 1'b0;
    toggle_hit   = 1'b0;
    toggle_idx   = rx_byte[3:0];
    abort        = 1'b0;
    if (rx.bu_rx_data_rdy) begin
      unique case (pstate_q)
        P_IDLE: begin
          if (rx_byte == CH_L) begin
            cmd_d    = CMD_TIME;
            pstate_d = P_D0;
          end else if (rx_byte == CH_A) begin
            cmd_d    = CMD_ALARM;
            pstate_d = P_SEL;
          end else if (rx_byte == CH_AT) begin
            cmd_d    = CMD_TOGGLE;
            pstate_d = P_SEL;
          end
        end
        P_SEL: begin
          if (!sel_ok) begin
            abort = 1'b1;
          end else if (cmd_q == CMD_TOGGLE) begin
            toggle_hit = 1'b1;
            pstate_d   = P_IDLE;
          end else begin
            sel_d    = rx_byte[3:0];
            pstate_d = P_D0;
          end
        end
        P_D0: if (digit_ok(rx_byte, 4'd5)) begin
          shadow_d[15:12] = rx_byte[3:0];
          pstate_d        = P_D1;
        end else abort = 1'b1;
        P_D1: if (digit_ok(rx_byte, 4'd9)) begin
          shadow_d[11:8] = rx_byte[3:0];
          pstate_d       = P_D2;
        end else abort = 1'b1;
        P_D2: if (digit_ok(rx_byte, 4'd5)) begin
          shadow_d[7:4] = rx_byte[3:0];
          pstate_d      = P_D3;
        end else abort = 1'b1;
        P_D3: if (digit_ok(rx_byte, 4'd9)) begin
          shadow_d[3:0] = rx_byte[3:0];
          pstate_d      = P_CR;
        end else abort = 1'b1;
        P_CR: begin
          if (rx_byte == CH_CR) begin
            commit_time  = (cmd_q == CMD_TIME);
            commit_alarm = (cmd_q == CMD_ALARM);
            pstate_d     = P_IDLE;
          end else begin
            abort = 1'b1;
          end
        end
        default: pstate_d = P_IDLE;
      endcase
    end
    if (abort) begin
      pstate_d = P_IDLE;
      shadow_d = '0;
      err_d    = 1'b1;
    end
  end

  // A time commit can only happen outside IDLE, so it always beats a strobe.
  always_comb begin
    time_d = time_q;
    if (commit_time) time_d = shadow_q;
    else if (tick)   time_d = bcd_inc(time_q);
    for (int i = 0; i < NUM_ALARMS; i++) begin
      alarm_d[i] = alarm_q[i];
      if (commit_alarm && sel_q == 4'(i)) alarm_d[i] = shadow_q;
    end
  end

`ifdef TRIG_TIMEOUT_EN
  logic [5:0] tmo_q [NUM_ALARMS];
  logic [5:0] tmo_d [NUM_ALARMS];

  // The counter idles at zero outside TRIG, which clears it on every entry.
  always_comb begin
    for (int i = 0; i < NUM_ALARMS; i++) begin
      tmo_d[i] = tmo_q[i];
      if (astate_q[i] != A_TRIG) tmo_d[i] = '0;
      else if (tick)             tmo_d[i] = tmo_q[i] + 6'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ALARMS; i++) tmo_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) tmo_q[i] <= tmo_d[i];
    end
  end
`endif

  always_comb begin
    for (int i = 0; i < NUM_ALARMS; i++) begin
      logic hit;
      hit         = toggle_hit && (toggle_idx == 4'(i));
      astate_d[i] = astate_q[i];
      unique case (astate_q[i])
        A_IDLE:  if (hit) astate_d[i] = A_ARMED;
        A_ARMED: begin
          if (hit)                          astate_d[i] = A_IDLE;
          else if (time_q == alarm_q[i])    astate_d[i] = A_TRIG;
        end
        A_TRIG: begin
          if (hit) astate_d[i] = A_IDLE;
`ifdef TRIG_TIMEOUT_EN
          else if (tick && tmo_q[i] == 6'd59) astate_d[i] = A_ARMED;
`endif
        end
        default: astate_d[i] = A_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pstate_q <= P_IDLE;
      cmd_q    <= CMD_TIME;
      sel_q    <= '0;
      shadow_q <= '0;
      err_q    <= 1'b0;
      time_q   <= '0;
      // NOTE: alarm values are an explicit reset target, so they live in flops, not a RAM.
      for (int i = 0; i < NUM_ALARMS; i++) begin
        alarm_q[i]  <= '0;
        astate_q[i] <= A_IDLE;
      end
    end else begin
      pstate_q <= pstate_d;
      cmd_q    <= cmd_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
      time_q   <= time_d;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        alarm_q[i]  <= alarm_d[i];
        astate_q[i] <= astate_d[i];
      end
    end
  end

  assign time_bcd = time_q;
  assign cmd_err  = err_q;

  always_comb begin
    alarm_bcd = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      armed[i] = (astate_q[i] == A_ARMED);
      trig[i]  = (astate_q[i] == A_TRIG);
      if (int'(alarm_sel) == i) alarm_bcd = alarm_q[i];
    end
  end

endmodule
